// File: rtl/riscv_pkg.sv
// Shared core package: op and state encodings used by the execute-stage units.
package riscv_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } div_state_t;

  function automatic logic op_is_signed(input div_op_t o);
    return (o == OP_DIV) || (o == OP_REM);
  endfunction

  function automatic logic op_is_rem(input div_op_t o);
    return (o == OP_REM) || (o == OP_REMU);
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider: one quotient bit per cycle, signed/unsigned DIV and REM,
// with RISC-V divide-by-zero and overflow results produced without iterating.
module div_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_addr,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      out_rd
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (-v) : v;
  endfunction

  div_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [4:0]      out_rd_q, out_rd_d;
  div_op_t         op_q, op_d;
  logic            neg1_q, neg1_d, neg2_q, neg2_d;
  logic [XLEN-1:0] quo_q, quo_d, dvs_q, dvs_d, rem_q, rem_d;

  // Request decode on the raw register-file operands
  div_op_t                op_in;
  logic                   sgn_in, neg1_in, neg2_in, ovf_in;
  logic signed [XLEN-1:0] rs1_s, rs2_s;

  assign op_in   = div_op_t'(op);
  assign sgn_in  = op_is_signed(op_in);
  assign rs1_s   = rs1_val;
  assign rs2_s   = rs2_val;
  assign neg1_in = sgn_in && (rs1_s < 0);
  assign neg2_in = sgn_in && (rs2_s < 0);
  assign ovf_in  = sgn_in && (rs1_val == MIN_NEG) && (rs2_val == '1);

  // One restoring step; the trial subtraction is one bit wider so its sign is the borrow
  logic [XLEN:0]   rem_sh, rem_sub;
  logic            take;
  logic [XLEN-1:0] rem_nx, quo_nx;

  assign rem_sh  = {rem_q, quo_q[XLEN-1]};
  assign rem_sub = rem_sh - {1'b0, dvs_q};
  assign take    = ~rem_sub[XLEN];
  assign rem_nx  = take ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_nx  = {quo_q[XLEN-2:0], take};

  assign in_ready  = (state_q == ST_IDLE) && !flush;
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign out_rd    = out_rd_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    out_rd_d = out_rd_q;
    op_d     = op_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          op_d     = op_in;
          out_rd_d = rd_addr;
          neg1_d   = neg1_in;
          neg2_d   = neg2_in;
          quo_d    = neg_if(neg1_in, rs1_val);
          dvs_d    = neg_if(neg2_in, rs2_val);
          rem_d    = '0;
          if (rs2_val == '0) begin
            state_d  = ST_DONE;
            result_d = op_is_rem(op_in) ? rs1_val : '1;
          end else if (ovf_in) begin
            state_d  = ST_DONE;
            result_d = op_is_rem(op_in) ? '0 : MIN_NEG;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_BUSY: begin
        rem_d = rem_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d  = ST_DONE;
          result_d = op_is_rem(op_q)
                   ? neg_if(neg1_q, rem_nx)
                   : neg_if(neg1_q ^ neg2_q, quo_nx);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      out_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      out_rd_q <= out_rd_d;
    end
  end

  // Working operands carry no reset: they are always loaded on accept before use
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    neg1_q <= neg1_d;
    neg2_q <= neg2_d;
    quo_q  <= quo_d;
    dvs_q  <= dvs_d;
    rem_q  <= rem_d;
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: hand-computed quotients/remainders, latency, hold, flush and reset.
module tb_div_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_addr;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic [4:0]      out_rd;

  int n_checks = 0;
  int n_errors = 0;

  div_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1_val   (rs1_val),
    .rs2_val   (rs2_val),
    .rd_addr   (rd_addr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .out_rd    (out_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request at a negedge, measure edges until out_valid, hold, then consume.
  // Latency 1 means out_valid is seen at the first edge after the accept edge.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; op = o; rs1_val = a; rs2_val = b; rd_addr = rd;
    #1 check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      #1 check({tag, ".ready_busy"}, 32'(in_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".result"}, result, exp);
    check({tag, ".out_rd"}, 32'(out_rd), 32'(rd));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".hold_result"}, result, exp);
      check({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".consumed"}, 32'(out_valid), 32'd0);
    check({tag, ".idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = 2'b00; rs1_val = '0; rs2_val = '0;
    rd_addr = '0; flush = 1'b0; out_ready = 1'b0;
    #3;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.out_rd", 32'(out_rd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("divu_100_7",  2'b01, 32'd100,       32'd7,          5'd5,  32'd14,         33, 0);
    run_op("div_m100_7",  2'b00, 32'hFFFFFF9C,  32'd7,          5'd6,  32'hFFFFFFF2,   33, 0);
    run_op("rem_m100_7",  2'b10, 32'hFFFFFF9C,  32'd7,          5'd7,  32'hFFFFFFFE,   33, 0);
    run_op("remu_100_7",  2'b11, 32'd100,       32'd7,          5'd8,  32'd2,          33, 0);
    run_op("div_100_m7",  2'b00, 32'd100,       32'hFFFFFFF9,   5'd9,  32'hFFFFFFF2,   33, 0);
    run_op("rem_100_m7",  2'b10, 32'd100,       32'hFFFFFFF9,   5'd10, 32'd2,          33, 0);
    run_op("divu_big",    2'b01, 32'hFFFFFFFF,  32'd2,          5'd11, 32'h7FFFFFFF,   33, 0);
    run_op("divu_nonovf", 2'b01, 32'h80000000,  32'hFFFFFFFF,   5'd12, 32'd0,          33, 0);
    run_op("div_m100_m7", 2'b00, 32'hFFFFFF9C,  32'hFFFFFFF9,   5'd0,  32'd14,         33, 0);
    run_op("remu_5_0",    2'b11, 32'd5,         32'd0,          5'd13, 32'd5,          1,  0);
    run_op("div_5_0",     2'b00, 32'd5,         32'd0,          5'd14, 32'hFFFFFFFF,   1,  0);
    run_op("rem_m7_0",    2'b10, 32'hFFFFFFF9,  32'd0,          5'd15, 32'hFFFFFFF9,   1,  0);
    run_op("div_ovf",     2'b00, 32'h80000000,  32'hFFFFFFFF,   5'd16, 32'h80000000,   1,  0);
    run_op("rem_ovf",     2'b10, 32'h80000000,  32'hFFFFFFFF,   5'd17, 32'd0,          1,  0);
    run_op("hold_div",    2'b00, 32'hFFFFFF9C,  32'd7,          5'd18, 32'hFFFFFFF2,   33, 10);

    // Flush at step 12 of a running op
    @(negedge clk);
    in_valid = 1'b1; op = 2'b01; rs1_val = 32'd100; rs2_val = 32'd7; rd_addr = 5'd19;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (11) @(negedge clk);
    flush = 1'b1;
    #1 check("flush.ready_low", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1 check("flush.idle_ready", 32'(in_ready), 32'd1);
    check("flush.out_valid", 32'(out_valid), 32'd0);
    watch_no_valid("flush.no_valid", 40);

    // Flush overrides a pending result in DONE
    @(negedge clk);
    in_valid = 1'b1; op = 2'b00; rs1_val = 32'd5; rs2_val = 32'd0; rd_addr = 5'd20;
    @(negedge clk);
    in_valid = 1'b0;
    check("flush_done.valid", 32'(out_valid), 32'd1);
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    check("flush_done.dropped", 32'(out_valid), 32'd0);

    // Asynchronous reset in the middle of a second op
    @(negedge clk);
    in_valid = 1'b1; op = 2'b00; rs1_val = 32'hFFFFFF9C; rs2_val = 32'd7; rd_addr = 5'd21;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("arst.out_valid", 32'(out_valid), 32'd0);
    check("arst.result", result, 32'd0);
    check("arst.out_rd", 32'(out_rd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("arst.ready_first", 32'(in_ready), 32'd1);
    watch_no_valid("arst.no_valid", 40);

    run_op("after_rst", 2'b10, 32'hFFFFFF9C, 32'd7, 5'd22, 32'hFFFFFFFE, 33, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
